// File: rtl/mul_issue_ctrl_pkg.sv
// rtl/mul_issue_ctrl_pkg.sv - shared types and helpers for the multiplier issue controller
// Contents: mul_op_e op encoding, meta_t in-flight metadata record,
//           default multiplier latency and tag width, operand magnitude helper.
package mul_issue_ctrl_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int MUL_TAG_W   = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  // One entry per operation travelling through the multiplier pipeline.
  typedef struct packed {
    logic                 hi;
    logic                 neg;
    logic [MUL_TAG_W-1:0] tag;
    logic                 kill;
  } meta_t;

  // Magnitude of a possibly-signed operand; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
    return (is_signed & x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_ctrl_fifo.sv
// rtl/mul_ctrl_fifo.sv - synchronous FIFO with clear and occupancy count
// Ports: clk, rst (async, active-high), clear (sync empty), push/push_data,
//        pop, head (oldest entry), empty, count (0..DEPTH).
// Callers never push when full or pop when empty; DEPTH is a power of two.
module mul_ctrl_fifo
  import mul_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - RV32M multiply issue, tag tracking and in-order result return
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready/in_op/in_a/in_b/in_tag : request handshake
//        flush                                    : kill all pending and in-flight work
//        out_valid/out_ready/out_data/out_tag     : in-order result handshake
//        mul_start/mul_a/mul_b                    : registered issue to the multiplier
//        mul_p/mul_done                           : product return from the multiplier
// Optional: MUL_CTRL_PERF_EN adds perf_issue_cnt and perf_stall_cnt.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int RES_DEPTH = 8,
  parameter int TAG_W     = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_p,
  input  logic             mul_done
`ifdef MUL_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int RW = 32 + TAG_W;

  if (RES_DEPTH < MUL_LAT + 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 || TAG_W != MUL_TAG_W)
  begin : g_param_check
    $error("mul_issue_ctrl: unsupported parameter combination");
  end

  mul_op_e       op;
  logic          a_signed;
  logic          b_signed;
  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nx;

  meta_t         meta_in;
  meta_t         meta_head;
  logic          meta_empty;
  logic [CW-1:0] meta_count;
  logic          meta_pop;
  logic [CW-1:0] kill_cnt;
  logic          kill_eff;
  logic          drop;

  logic [63:0]   prod;
  logic [31:0]   res_data;
  logic          res_push;
  logic [RW-1:0] res_head;
  logic          res_empty;
  logic [CW-1:0] res_count;

  assign op       = mul_op_e'(in_op);
  assign a_signed = (op != OP_MULHU);
  assign b_signed = (op == OP_MUL) || (op == OP_MULH);

  assign in_ready = (credits != '0) & ~flush;
  assign in_fire  = in_valid & in_ready;

  // Issue stage: operands are converted to magnitudes and registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_start <= in_fire;
      if (in_fire) begin
        mul_a <= mag(in_a, a_signed);
        mul_b <= mag(in_b, b_signed);
      end
    end
  end

  assign meta_in.hi   = (op != OP_MUL);
  assign meta_in.neg  = (a_signed & in_a[31]) ^ (b_signed & in_b[31]);
  assign meta_in.tag  = in_tag;
  assign meta_in.kill = 1'b0;

  mul_ctrl_fifo #(
    .WIDTH($bits(meta_t)),
    .DEPTH(RES_DEPTH)
  ) u_meta_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .push     (in_fire),
    .push_data(meta_in),
    .pop      (meta_pop),
    .head     (meta_head),
    .empty    (meta_empty),
    .count    (meta_count)
  );

  // A flush kills every entry present, so killed entries always form a
  // prefix of the metadata FIFO. Counting that prefix stands in for
  // rewriting the kill bit in each stored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_cnt <= '0;
    end else if (flush) begin
      kill_cnt <= meta_count - CW'(meta_pop);
    end else if (meta_pop && kill_cnt != '0) begin
      kill_cnt <= kill_cnt - CW'(1);
    end
  end

  // A product returning in the flush cycle itself is killed too.
  assign meta_pop = mul_done & ~meta_empty;
  assign kill_eff = meta_head.kill | (kill_cnt != '0) | flush;
  assign drop     = meta_pop & kill_eff;
  assign res_push = meta_pop & ~kill_eff;

  assign prod     = meta_head.neg ? (~mul_p + 64'd1) : mul_p;
  assign res_data = meta_head.hi ? prod[63:32] : prod[31:0];

  mul_ctrl_fifo #(
    .WIDTH(RW),
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (res_push),
    .push_data({res_data, meta_head.tag}),
    .pop      (out_fire),
    .head     (res_head),
    .empty    (res_empty),
    .count    (res_count)
  );

  assign {out_data, out_tag} = res_head;
  assign out_valid = ~res_empty & ~flush;
  assign out_fire  = out_valid & out_ready;

  // Net credit change of all events in this cycle; a credit covers one
  // operation from issue until its result leaves or is discarded.
  always_comb begin
    credits_nx = credits - CW'(in_fire) + CW'(out_fire) + CW'(drop);
    if (flush) credits_nx = credits_nx + res_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) credits <= CW'(RES_DEPTH);
    else     credits <= credits_nx;
  end

`ifdef MUL_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (in_fire)              perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (in_valid & ~in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - scoreboard bench for mul_issue_ctrl with a behavioural multiplier
module tb_mul_issue_ctrl;

  localparam int MUL_LAT   = 4;
  localparam int RES_DEPTH = 8;
  localparam int TAG_W     = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             mul_start;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_p;
  logic             mul_done;
`ifdef MUL_CTRL_PERF_EN
  logic [31:0]      perf_issue_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  logic [36:0] exp_q[$];
  int pop_cyc[$];
  logic [36:0] mon_e;

  mul_issue_ctrl #(
    .MUL_LAT  (MUL_LAT),
    .RES_DEPTH(RES_DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .mul_start(mul_start),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
`ifdef MUL_CTRL_PERF_EN
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .mul_done (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural fixed-latency unsigned multiplier sharing rst.
  logic [MUL_LAT-1:0] pv;
  logic [63:0]        pp [MUL_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < MUL_LAT; i++) pp[i] <= '0;
    end else begin
      pv    <= {pv[MUL_LAT-2:0], mul_start};
      pp[0] <= {32'd0, mul_a} * {32'd0, mul_b};
      for (int i = 1; i < MUL_LAT; i++) pp[i] <= pp[i-1];
    end
  end
  assign mul_done = pv[MUL_LAT-1];
  assign mul_p    = pp[MUL_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every result handed over is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual tag=%0d data=%0h required=none", out_tag, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_data", {32'd0, out_data}, {32'd0, mon_e[36:5]});
        chk("result_tag", {59'd0, out_tag}, {59'd0, mon_e[4:0]});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] expd);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    if (!in_ready) stall_cnt++;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready=0 required=1");
    end else begin
      exp_q.push_back({expd, tag});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", name}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic lat_test(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] expd,
                          input logic [31:0] ema, input logic [31:0] emb);
    int lat;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    exp_q.push_back({expd, tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_mul_start", mul_start, 1);
    chk("lat_mul_a", mul_a, ema);
    chk("lat_mul_b", mul_b, emb);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("lat_cycles", lat, 6);
    wait_drain("lat");
  endtask

  // out_ready held low, in_valid held high for 20 cycles: count acceptances.
  task automatic fill_stalled(input string name, input logic [31:0] base);
    int  acc;
    logic took;
    acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = base; in_b = 32'd1; in_tag = 5'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        exp_q.push_back({base + 32'(acc), 5'(acc)});
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        in_a   = base + 32'(acc);
        in_tag = 5'(acc);
      end
    end
    in_valid = 1'b0;
    chk({name, "_accepted"}, acc, RES_DEPTH);
    @(negedge clk);
    chk({name, "_in_ready_low"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(name);
    @(negedge clk);
    chk({name, "_in_ready_back"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    @(posedge clk); #1;

    // MUL -1 * 2
    lat_test(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFE, 32'd1, 32'd2);

    // Directed signedness / boundary vectors, issued back to back.
    send(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    send(2'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
    send(2'd1, 32'hFFFF_FFFE, 32'd3,         5'd7, 32'hFFFF_FFFF);
    send(2'd3, 32'h8000_0000, 32'd2,         5'd8, 32'h0000_0001);
    send(2'd2, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'hC000_0000);
    wait_drain("directed");

    // 20 back-to-back MULs, i*3, tags 0..19.
    stall_cnt = 0;
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) send(2'd0, 32'(i), 32'd3, 5'(i), 32'(3 * i));
    chk("b2b_no_stall", stall_cnt, 0);
    wait_drain("b2b");
    chk("b2b_count", pop_cyc.size(), 20);
    if (pop_cyc.size() == 20) chk("b2b_one_per_cycle", pop_cyc[19] - pop_cyc[0], 19);

    // Backpressure: exactly RES_DEPTH accepted, then in order drain.
    fill_stalled("stall", 32'd100);

    // Flush with 2 buffered and 3 in flight.
    out_ready = 1'b0;
    send(2'd0, 32'd2, 32'd3, 5'd1, 32'd6);
    send(2'd0, 32'd4, 32'd5, 5'd2, 32'd20);
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_flush_out_valid", out_valid, 1);
    @(posedge clk); #1;
    send(2'd0, 32'd6, 32'd7, 5'd3, 32'd42);
    send(2'd0, 32'd8, 32'd9, 5'd4, 32'd72);
    send(2'd0, 32'd10, 32'd11, 5'd5, 32'd110);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    fill_stalled("post_flush", 32'd200);

    // Reset in the middle of a stream.
    out_ready = 1'b1;
    send(2'd0, 32'd1, 32'd1, 5'd1, 32'd1);
    send(2'd0, 32'd2, 32'd2, 5'd2, 32'd4);
    send(2'd0, 32'd3, 32'd3, 5'd3, 32'd9);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_mul_start", mul_start, 0);
    chk("midrst_mul_a", mul_a, 0);
    chk("midrst_mul_b", mul_b, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_test(2'd0, 32'd5, 32'd6, 5'd7, 32'd30, 32'd5, 32'd6);

    repeat (10) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
